diff_tx_serializer: RTL



---
 rtl/diff_tx_if.sv | 30 +++
 rtl/diff_tx_serializer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/diff_tx_if.sv
// Load handshake and line-side signals of the differential serial transmitter.
// The slave modport is the transmitter; the master modport is the word producer.
interface diff_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             dout;
  logic             busy;
  logic             frame_done;

  modport master (
    output load_data,
    output load_valid,
    input  load_ready,
    input  dout,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  load_data,
    input  load_valid,
    output load_ready,
    output dout,
    output busy,
    output frame_done
  );
endinterface

// File: rtl/diff_tx_serializer.sv
// Framed parallel-to-serial transmitter with differential (XNOR-inverse) line coding.
// Optional even-parity bit after the LSB when DIFF_TX_PARITY_EN is defined.
module diff_tx_serializer #(
  parameter int WIDTH = 8
) (
  input logic     clk,
  input logic     rst,
  diff_tx_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

`ifdef DIFF_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] hold;
  logic             hold_valid;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    cnt;
  logic             dout_q;
  logic             frame_done_q;
  logic             load_shift;
  logic             raw;
  logic             accept;
`ifdef DIFF_TX_PARITY_EN
  logic             hold_par;
  logic             par_reg;
`endif

  // Line coding: the downstream decoder recovers XNOR of two consecutive samples.
  function automatic logic diff_enc(input logic prev, input logic b);
    return ~(prev ^ b);
  endfunction

  assign accept = bus.load_valid && !hold_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_shift = 1'b0;
    raw        = 1'b1;
    case (state)
      IDLE: begin
        if (hold_valid) begin
          state_nxt  = START;
          load_shift = 1'b1;
        end
      end
      START: begin
        raw       = 1'b0;
        state_nxt = DATA;
      end
      DATA: begin
        raw = shift_reg[WIDTH-1];
        if (cnt == '0) begin
`ifdef DIFF_TX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef DIFF_TX_PARITY_EN
      PARITY: begin
        raw       = par_reg;
        state_nxt = STOP;
      end
`endif
      STOP: begin
        raw = 1'b1;
        if (hold_valid) begin
          state_nxt  = START;
          load_shift = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Hold buffer payload is pure data; only its valid flag is reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold <= bus.load_data;
`ifdef DIFF_TX_PARITY_EN
      hold_par <= ^bus.load_data;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid   <= 1'b0;
      shift_reg    <= '0;
      cnt          <= '0;
      dout_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef DIFF_TX_PARITY_EN
      par_reg      <= 1'b0;
`endif
    end else begin
      dout_q       <= diff_enc(dout_q, raw);
      frame_done_q <= (state == STOP);
      if (load_shift) begin
        shift_reg  <= hold;
        cnt        <= CW'(WIDTH - 1);
        hold_valid <= 1'b0;
`ifdef DIFF_TX_PARITY_EN
        par_reg    <= hold_par;
`endif
      end else if (state == DATA) begin
        shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
        cnt       <= cnt - CW'(1);
      end
      // accept requires an empty hold, load_shift a full one: never both
      if (accept) hold_valid <= 1'b1;
    end
  end

  assign bus.load_ready = ~hold_valid;
  assign bus.dout       = dout_q;
  assign bus.busy       = (state != IDLE);
  assign bus.frame_done = frame_done_q;

endmodule
